// File: rtl/ifid_skid_reg.sv
// IF->ID pipeline stage with a two-entry skid buffer (SKID_EN=1) or a single
// register (SKID_EN=0). One entry carries instruction, PC and sideband as a
// single unit. A flush empties the stage and counts every valid entry it
// discards. Outputs show NOP/0/0 whenever no entry is presented.
//
// Handshake: an entry moves across an interface in the cycle where its valid
// and ready are both high at the rising clock edge. Valid must not depend on
// ready. A producer holds its payload stable while valid is high and ready is
// low. With SKID_EN=1, in_ready is decoded from registered state only.
module ifid_skid_reg #(
  parameter int              XLEN       = 32,
  parameter int              SIDE_W     = 4,
  parameter logic [XLEN-1:0] NOP_INSTR  = XLEN'(32'h00000013),
  parameter bit              SKID_EN    = 1'b1,
  parameter int              DROP_CNT_W = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  flush_i,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [XLEN-1:0]       in_instr,
  input  logic [XLEN-1:0]       in_pc,
  input  logic [SIDE_W-1:0]     in_side,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [XLEN-1:0]       out_instr,
  output logic [XLEN-1:0]       out_pc,
  output logic [SIDE_W-1:0]     out_side,
  output logic [1:0]            level_o,
  output logic [DROP_CNT_W-1:0] drop_cnt_o
);

  // The state encoding equals the number of entries held, so level_o is the
  // FSM state seen directly.
  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } state_t;

  state_t state, state_n;

  logic [XLEN-1:0]   main_instr, main_pc, skid_instr, skid_pc;
  logic [SIDE_W-1:0] main_side, skid_side;
  logic              push, pop, accept;
  logic              ld_main_in, ld_main_skid, ld_skid;
  logic [1:0]        drop_inc;
  logic [DROP_CNT_W+1:0] drop_sum;
  logic [DROP_CNT_W-1:0] drop_cnt;

  assign out_valid = (state != ST_EMPTY);
  assign level_o   = state;

  // In skid mode ready depends only on state. In single mode it passes
  // out_ready through combinationally.
  always_comb begin
    if (SKID_EN) in_ready = (state != ST_FULL);
    else         in_ready = (state == ST_EMPTY) | out_ready;
  end

  assign accept = in_valid & in_ready;
  assign push   = accept & ~flush_i;
  assign pop    = out_valid & out_ready;

  // Next-state and payload-steering decode. Flush overrides every transition.
  always_comb begin
    state_n      = state;
    ld_main_in   = 1'b0;
    ld_main_skid = 1'b0;
    ld_skid      = 1'b0;
    if (SKID_EN) begin
      case (state)
        ST_EMPTY: begin
          if (push) begin
            state_n    = ST_ONE;
            ld_main_in = 1'b1;
          end
        end
        ST_ONE: begin
          if (push && !pop) begin
            state_n = ST_FULL;
            ld_skid = 1'b1;
          end else if (push && pop) begin
            ld_main_in = 1'b1;
          end else if (pop) begin
            state_n = ST_EMPTY;
          end
        end
        ST_FULL: begin
          if (pop) begin
            state_n      = ST_ONE;
            ld_main_skid = 1'b1;
          end
        end
        default: state_n = ST_EMPTY;
      endcase
    end else begin
      if (push) begin
        state_n    = ST_ONE;
        ld_main_in = 1'b1;
      end else if (pop) begin
        state_n = ST_EMPTY;
      end
    end
    if (flush_i) state_n = ST_EMPTY;
  end

  // The flush discards held entries except one popped this cycle, plus an
  // incoming entry that was accepted. The sum saturates at all-ones.
  always_comb begin
    drop_inc = level_o - {1'b0, pop} + {1'b0, accept};
    drop_sum = {2'b00, drop_cnt} + (DROP_CNT_W+2)'(drop_inc);
    if (drop_sum[DROP_CNT_W+1:DROP_CNT_W] != 2'b00) drop_sum = {2'b00, {DROP_CNT_W{1'b1}}};
  end

  // State register and flush-drop counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_EMPTY;
      drop_cnt <= '0;
    end else begin
      state <= state_n;
      if (flush_i) drop_cnt <= drop_sum[DROP_CNT_W-1:0];
    end
  end

  // Payload registers. The main register feeds the outputs, and the skid
  // register holds the entry that arrived while decode stalled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      main_instr <= NOP_INSTR;
      main_pc    <= '0;
      main_side  <= '0;
      skid_instr <= NOP_INSTR;
      skid_pc    <= '0;
      skid_side  <= '0;
    end else begin
      if (ld_main_in) begin
        main_instr <= in_instr;
        main_pc    <= in_pc;
        main_side  <= in_side;
      end else if (ld_main_skid) begin
        main_instr <= skid_instr;
        main_pc    <= skid_pc;
        main_side  <= skid_side;
      end
      if (ld_skid) begin
        skid_instr <= in_instr;
        skid_pc    <= in_pc;
        skid_side  <= in_side;
      end
    end
  end

  assign drop_cnt_o = drop_cnt;
  assign out_instr  = out_valid ? main_instr : NOP_INSTR;
  assign out_pc     = out_valid ? main_pc    : '0;
  assign out_side   = out_valid ? main_side  : '0;

endmodule
